decode: RTL and testbench
=========================

Name: decode

Overview:
- LC-3 decode stage, directly downstream of the fetch stage.
- Captures the instruction word returned by instruction memory together with the fetch stage's npc.
- Registers IR and npc, and generates registered control words for execute (E_Control), memory (Mem_Control) and writeback (W_Control).
- Also flags unsupported opcodes and supports pipeline flush on taken branches.

Parameters:
- NOP_INSTR, 16'h0000, instruction word loaded into IR on reset or flush (BR with nzp=000, i.e. no-op).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- enable_decode  input  1  capture dout/npc_in and decode this cycle.
- flush  input  1  discard the instruction in decode (driven by branch taken).
- dout  input  16  instruction word from instruction memory.
- npc_in  input  16  npc from fetch (PC+1 of the fetched instruction).
- IR  output  16  registered instruction.
- npc_out  output  16  registered npc.
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  output  2  writeback select: 00 ALU result, 01 memory data, 10 computed address (pcout).
- Mem_Control  output  1  1 = indirect access (LDI/STI, two memory phases).
- illegal  output  1  registered: captured opcode is unsupported.
- de_valid  output  1  1 for exactly the cycle after a non-flushed capture.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - IR=NOP_INSTR; npc_out=0; E_Control=0; W_Control=0; Mem_Control=0; illegal=0; de_valid=0.
  - Takes effect immediately, even mid-operation.
  - First capture possible on the first posedge after rst rises.
- Priority at posedge: flush > enable_decode > hold.
- flush=1:
  - IR=NOP_INSTR; all control outputs 0; illegal=0; de_valid=0.
  - npc_out holds its previous value.
- enable_decode=1, flush=0: latency one clock. On the posedge:
  - IR<=dout; npc_out<=npc_in; controls <= decode(dout); de_valid<=1.
- enable_decode=0, flush=0:
  - All registers hold; de_valid<=0.
  - Back-to-back enables give de_valid=1 continuously.
- Decode is purely on dout[15:12] (op) plus dout[5] for ADD/AND. Encodings as {alu, pcsel1, pcsel2, op2sel}, W, Mem:
  - ADD 0001: alu=00, pcsel1=00, pcsel2=0, op2sel=~dout[5], W=00, Mem=0.
  - AND 0101: same as ADD but alu=01.
  - NOT 1001: alu=10, pcsel1=00, pcsel2=0, op2sel=1, W=00, Mem=0.
  - BR 0000: alu=00, pcsel1=01 (offset9), pcsel2=1 (npc base), op2sel=0, W=00, Mem=0.
  - JMP 1100: pcsel1=11 (zero offset), pcsel2=0 (BaseR), W=00, Mem=0.
  - LD 0010: pcsel1=01, pcsel2=1, W=01, Mem=0.
  - LDR 0110: pcsel1=10 (offset6), pcsel2=0, W=01, Mem=0.
  - LDI 1010: pcsel1=01, pcsel2=1, W=01, Mem=1.
  - LEA 1110: pcsel1=01, pcsel2=1, W=10, Mem=0.
  - ST 0011: pcsel1=01, pcsel2=1, W=00, Mem=0.
  - STR 0111: pcsel1=10, pcsel2=0, W=00, Mem=0.
  - STI 1011: pcsel1=01, pcsel2=1, W=00, Mem=1.
  - Unlisted fields in the rows above are 0.
  - JSR 0100, RTI 1000, 1101, TRAP 1111: E_Control=0, W=00, Mem=0, illegal=1. IR and npc_out are still captured and de_valid=1.
- dout containing X/Z while enable_decode=1 is a bench error; no X-masking is required.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive rst=0 asynchronously mid-cycle after loading state → all outputs go to reset values before the next posedge; IR=16'h0000, de_valid=0.
- ALU decode:
  - enable_decode=1, dout=16'h1042 (ADD reg), npc_in=16'h3001 → next cycle IR=16'h1042, npc_out=16'h3001, E_Control=6'b000001, W=00, de_valid=1.
  - Then dout=16'h5060 (AND imm) → E_Control=6'b010000.
- Memory decode:
  - dout=16'hA205 (LDI) → E_Control=6'b000110, W=01, Mem=1.
  - dout=16'h6283 (LDR) → E_Control=6'b001000, W=01, Mem=0.
  - dout=16'hE1FF (LEA) → W=10.
- Hold: enable_decode=0 for 3 cycles while dout changes → IR/npc_out/controls unchanged; de_valid=0.
- Flush priority: flush=1 and enable_decode=1 with dout=16'h1042 → IR=16'h0000, controls 0, de_valid=0, npc_out unchanged.
- Illegal: dout=16'hF025 (TRAP) → illegal=1, E_Control=0, IR=16'hF025. Next capture of 16'h1042 → illegal=0.

Source files
------------

// File: rtl/decode.sv
// LC-3 decode stage: registers the fetched instruction and npc and produces registered
// control words for execute, memory and writeback; one-clock latency, flush wins over capture.
module decode #(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_decode,
  input  logic        flush,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        illegal,
  output logic        de_valid
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0] op;
  logic [1:0] alu;
  logic [1:0] pcsel1;
  logic       pcsel2;
  logic       op2sel;
  logic [1:0] wsel;
  logic       mem;
  logic       bad_op;

  assign op = dout[15:12];

  // Address-forming ops pick offset source in pcsel1 and base (npc vs BaseR) in pcsel2.
  always_comb begin
    alu    = 2'b00;
    pcsel1 = 2'b00;
    pcsel2 = 1'b0;
    op2sel = 1'b0;
    wsel   = 2'b00;
    mem    = 1'b0;
    bad_op = 1'b0;
    case (op)
      OP_ADD: op2sel = ~dout[5];
      OP_AND: begin alu = 2'b01; op2sel = ~dout[5]; end
      OP_NOT: begin alu = 2'b10; op2sel = 1'b1; end
      OP_BR:  begin pcsel1 = 2'b01; pcsel2 = 1'b1; end
      OP_JMP: pcsel1 = 2'b11;
      OP_LD:  begin pcsel1 = 2'b01; pcsel2 = 1'b1; wsel = 2'b01; end
      OP_LDR: begin pcsel1 = 2'b10; wsel = 2'b01; end
      OP_LDI: begin pcsel1 = 2'b01; pcsel2 = 1'b1; wsel = 2'b01; mem = 1'b1; end
      OP_LEA: begin pcsel1 = 2'b01; pcsel2 = 1'b1; wsel = 2'b10; end
      OP_ST:  begin pcsel1 = 2'b01; pcsel2 = 1'b1; end
      OP_STR: pcsel1 = 2'b10;
      OP_STI: begin pcsel1 = 2'b01; pcsel2 = 1'b1; mem = 1'b1; end
      default: bad_op = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IR          <= NOP_INSTR;
      npc_out     <= 16'h0000;
      E_Control   <= 6'b0;
      W_Control   <= 2'b00;
      Mem_Control <= 1'b0;
      illegal     <= 1'b0;
      de_valid    <= 1'b0;
    end else if (flush) begin
      // npc_out deliberately keeps its last value across a flush.
      IR          <= NOP_INSTR;
      E_Control   <= 6'b0;
      W_Control   <= 2'b00;
      Mem_Control <= 1'b0;
      illegal     <= 1'b0;
      de_valid    <= 1'b0;
    end else if (enable_decode) begin
      IR          <= dout;
      npc_out     <= npc_in;
      E_Control   <= {alu, pcsel1, pcsel2, op2sel};
      W_Control   <= wsel;
      Mem_Control <= mem;
      illegal     <= bad_op;
      de_valid    <= 1'b1;
    end else begin
      de_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed vector table, async reset and flush sequences, random run vs model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_decode = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] dout = 16'h0;
  logic [15:0] npc_in = 16'h0;
  logic [15:0] ir, npc_out;
  logic [5:0]  e_ctl;
  logic [1:0]  w_ctl;
  logic        mem_ctl, illegal, de_valid;

  int total = 0;
  int bad = 0;

  decode dut (
    .clk(clk), .rst(rst), .enable_decode(enable_decode), .flush(flush),
    .dout(dout), .npc_in(npc_in), .IR(ir), .npc_out(npc_out),
    .E_Control(e_ctl), .W_Control(w_ctl), .Mem_Control(mem_ctl),
    .illegal(illegal), .de_valid(de_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        fl;
    logic [15:0] d;
    logic [15:0] n;
    logic [15:0] x_ir;
    logic [15:0] x_npc;
    logic [5:0]  x_e;
    logic [1:0]  x_w;
    logic        x_mem;
    logic        x_ill;
    logic        x_vld;
  } vec_t;

  vec_t vecs[15];

  // Reference model: per-opcode lookup tables transcribed from the encoding list.
  logic [1:0] alu_t[16];
  logic [1:0] pc1_t[16];
  logic       pc2_t[16];
  logic [1:0] w_t[16];
  logic       mem_t[16];
  logic       ill_t[16];

  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_mem, m_ill, m_vld;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".IR"}, ir, m_ir);
    chk({tag, ".npc"}, npc_out, m_npc);
    chk({tag, ".E"}, {10'b0, e_ctl}, {10'b0, m_e});
    chk({tag, ".W"}, {14'b0, w_ctl}, {14'b0, m_w});
    chk({tag, ".mem"}, {15'b0, mem_ctl}, {15'b0, m_mem});
    chk({tag, ".ill"}, {15'b0, illegal}, {15'b0, m_ill});
    chk({tag, ".vld"}, {15'b0, de_valid}, {15'b0, m_vld});
  endtask

  task automatic model_reset();
    m_ir = 16'h0; m_npc = 16'h0; m_e = 6'b0; m_w = 2'b0;
    m_mem = 1'b0; m_ill = 1'b0; m_vld = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic fl, input logic [15:0] d, input logic [15:0] n);
    int op;
    logic op2;
    op = int'(d[15:12]);
    if (fl) begin
      m_ir = 16'h0; m_e = 6'b0; m_w = 2'b0; m_mem = 1'b0; m_ill = 1'b0; m_vld = 1'b0;
    end else if (en) begin
      if (op == 1 || op == 5) op2 = ~d[5];
      else op2 = (op == 9);
      m_ir = d; m_npc = n;
      m_e = {alu_t[op], pc1_t[op], pc2_t[op], op2};
      m_w = w_t[op]; m_mem = mem_t[op]; m_ill = ill_t[op]; m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
  endtask

  task automatic step(input logic en, input logic fl, input logic [15:0] d, input logic [15:0] n);
    @(negedge clk);
    enable_decode = en; flush = fl; dout = d; npc_in = n;
    @(posedge clk);
    model_step(en, fl, d, n);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      alu_t[i] = 2'b00; pc1_t[i] = 2'b00; pc2_t[i] = 1'b0;
      w_t[i] = 2'b00; mem_t[i] = 1'b0; ill_t[i] = 1'b0;
    end
    alu_t[5] = 2'b01; alu_t[9] = 2'b10;
    pc1_t[0] = 2'b01; pc2_t[0] = 1'b1;
    pc1_t[12] = 2'b11;
    pc1_t[2] = 2'b01; pc2_t[2] = 1'b1; w_t[2] = 2'b01;
    pc1_t[6] = 2'b10; w_t[6] = 2'b01;
    pc1_t[10] = 2'b01; pc2_t[10] = 1'b1; w_t[10] = 2'b01; mem_t[10] = 1'b1;
    pc1_t[14] = 2'b01; pc2_t[14] = 1'b1; w_t[14] = 2'b10;
    pc1_t[3] = 2'b01; pc2_t[3] = 1'b1;
    pc1_t[7] = 2'b10;
    pc1_t[11] = 2'b01; pc2_t[11] = 1'b1; mem_t[11] = 1'b1;
    ill_t[4] = 1'b1; ill_t[8] = 1'b1; ill_t[13] = 1'b1; ill_t[15] = 1'b1;

    //            en  fl  dout      npc       IR        npc_out   E          W      mem   ill   vld
    vecs[0]  = '{1'b1, 1'b0, 16'h1042, 16'h3001, 16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 16'h5060, 16'h3002, 16'h5060, 16'h3002, 6'b010000, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 16'hA205, 16'h3003, 16'hA205, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 16'h6283, 16'h3004, 16'h6283, 16'h3004, 6'b001000, 2'b01, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'hE1FF, 16'h3005, 16'hE1FF, 16'h3005, 6'b000110, 2'b10, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'h1111, 16'h7777, 16'hE1FF, 16'h3005, 6'b000110, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h2222, 16'h8888, 16'hE1FF, 16'h3005, 6'b000110, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'hB333, 16'h9999, 16'hE1FF, 16'h3005, 6'b000110, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'h1042, 16'h4000, 16'h0000, 16'h3005, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'hF025, 16'h3006, 16'hF025, 16'h3006, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 16'h1042, 16'h3007, 16'h1042, 16'h3007, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 16'h0E05, 16'h3008, 16'h0E05, 16'h3008, 6'b000110, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 16'hC1C0, 16'h3009, 16'hC1C0, 16'h3009, 6'b001100, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 16'h927F, 16'h300A, 16'h927F, 16'h300A, 6'b100001, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'hBE01, 16'h300B, 16'hBE01, 16'h300B, 6'b000110, 2'b00, 1'b1, 1'b0, 1'b1};

    // Reset values while rst is held low.
    #12;
    model_reset();
    chk_model("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      enable_decode = vecs[i].en; flush = vecs[i].fl; dout = vecs[i].d; npc_in = vecs[i].n;
      @(posedge clk);
      #1;
      chk({tag, ".IR"}, ir, vecs[i].x_ir);
      chk({tag, ".npc"}, npc_out, vecs[i].x_npc);
      chk({tag, ".E"}, {10'b0, e_ctl}, {10'b0, vecs[i].x_e});
      chk({tag, ".W"}, {14'b0, w_ctl}, {14'b0, vecs[i].x_w});
      chk({tag, ".mem"}, {15'b0, mem_ctl}, {15'b0, vecs[i].x_mem});
      chk({tag, ".ill"}, {15'b0, illegal}, {15'b0, vecs[i].x_ill});
      chk({tag, ".vld"}, {15'b0, de_valid}, {15'b0, vecs[i].x_vld});
    end

    // Mid-cycle asynchronous reset: outputs clear before the next posedge.
    @(negedge clk);
    enable_decode = 1'b1; flush = 1'b0; dout = 16'h2ABC; npc_in = 16'h5555;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_model("async_rst");
    @(negedge clk);
    enable_decode = 1'b0;
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h1042, 16'h5000);
    chk_model("first_cap");
    step(1'b1, 1'b0, 16'h3FFF, 16'h5001);
    chk_model("b2b");
    step(1'b1, 1'b1, 16'h1042, 16'h6000);
    chk_model("flush2");
    step(1'b0, 1'b0, 16'hABCD, 16'h6001);
    chk_model("post_flush_hold");

    // Randomized run against the lookup-table model.
    for (int k = 0; k < 400; k++) begin
      logic en, fl;
      logic [15:0] d, n;
      en = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 9) == 0);
      d = 16'($urandom);
      n = 16'($urandom);
      step(en, fl, d, n);
      chk_model($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
